lift_run_ctrl: RTL

- Motion/run controller for the 4-floor elevator.
- Consumes the latched, active-low floor requests, the `arrival` flag and the `door` flag from the floor-request block.
- Produces the current floor `c_floor`, the run direction `drc` and the one-cycle floor-change strobe `lock` that the floor-request block samples.
- Uses SCAN scheduling: keeps the current direction while requests remain ahead, reverses when none remain, idles when no requests remain.

---
 rtl/lift_pkg.sv | 31 +++
 rtl/lift_run_ctrl_if.sv | 24 ++
 rtl/lift_travel_timer.sv | 23 ++
 rtl/lift_run_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared encodings for the lift controller slice: floor codes, direction codes,
// run-controller states and the SCAN direction decision.
package lift_pkg;

  localparam logic [1:0] F1 = 2'b00;
  localparam logic [1:0] F2 = 2'b01;
  localparam logic [1:0] F3 = 2'b10;
  localparam logic [1:0] F4 = 2'b11;

  localparam logic [1:0] DRC_WAIT = 2'b00;
  localparam logic [1:0] DRC_UP   = 2'b01;
  localparam logic [1:0] DRC_DN   = 2'b10;

  typedef enum logic [1:0] {WAIT, RUN, CHECK, HOLD} state_t;

  // Keep going while requests lie ahead, otherwise take whichever side has
  // work (up first), otherwise stop.
  function automatic logic [1:0] scan_next(input logic [1:0] drc,
                                           input logic       above,
                                           input logic       below,
                                           input logic [1:0] floor);
    logic [1:0] nxt;
    nxt = DRC_WAIT;
    if (drc == DRC_UP && above && floor != F4)      nxt = DRC_UP;
    else if (drc == DRC_DN && below && floor != F1) nxt = DRC_DN;
    else if (above)                                 nxt = DRC_UP;
    else if (below)                                 nxt = DRC_DN;
    return nxt;
  endfunction

endpackage

// File: rtl/lift_run_ctrl_if.sv
// Bundle between the floor-request block (master) and the run controller (slave).
interface lift_run_ctrl_if;
  logic       Fout_1up, Fout_2up, Fout_3up;
  logic       Fout_2dn, Fout_3dn, Fout_4dn;
  logic       Fout_1, Fout_2, Fout_3, Fout_4;
  logic       arrival;
  logic       door;
  logic       err;
  logic [1:0] c_floor;
  logic [1:0] drc;
  logic       lock;

  modport master (
    output Fout_1up, Fout_2up, Fout_3up, Fout_2dn, Fout_3dn, Fout_4dn,
    output Fout_1, Fout_2, Fout_3, Fout_4, arrival, door, err,
    input  c_floor, drc, lock
  );

  modport slave (
    input  Fout_1up, Fout_2up, Fout_3up, Fout_2dn, Fout_3dn, Fout_4dn,
    input  Fout_1, Fout_2, Fout_3, Fout_4, arrival, door, err,
    output c_floor, drc, lock
  );
endinterface

// File: rtl/lift_travel_timer.sv
// Inter-floor travel timer: counts while enabled, pulses done on the last
// cycle of a floor-to-floor move and wraps back to zero.
module lift_travel_timer #(
  parameter int T_FLOOR = 2000,
  parameter int TW      = 16
) (
  input  logic clk_1KHz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);

  logic [TW-1:0] count;

  assign done = en && !clr && (count == TW'(T_FLOOR - 1));

  always_ff @(posedge clk_1KHz) begin
    if (rst || clr || done) count <= '0;
    else if (en)            count <= count + TW'(1);
  end

endmodule

// File: rtl/lift_run_ctrl.sv
// SCAN motion controller for the 4-floor lift: tracks the car floor, run
// direction and issues a one-cycle lock strobe on every floor change.
module lift_run_ctrl
  import lift_pkg::*;
#(
  parameter int T_FLOOR  = 2000,
  parameter int ARR_WAIT = 3,
  parameter int TW       = 16
) (
  input logic          clk_1KHz,
  input logic          rst,
  lift_run_ctrl_if.slave bus
);

  state_t     state, state_n;
  logic [1:0] drc_q, drc_n;
  logic [1:0] floor_q, floor_n;
  logic       lock_q, lock_n;
  logic [7:0] cnt_q, cnt_n;
  logic [3:0] req_at;
  logic       above, below;
  logic       t_en, t_clr, t_done;

  assign req_at[0] = ~bus.Fout_1up | ~bus.Fout_1;
  assign req_at[1] = ~bus.Fout_2up | ~bus.Fout_2dn | ~bus.Fout_2;
  assign req_at[2] = ~bus.Fout_3up | ~bus.Fout_3dn | ~bus.Fout_3;
  assign req_at[3] = ~bus.Fout_4dn | ~bus.Fout_4;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned f = 0; f < 4; f++) begin
      if (2'(f) > floor_q) above = above | req_at[f];
      if (2'(f) < floor_q) below = below | req_at[f];
    end
  end

  lift_travel_timer #(.T_FLOOR(T_FLOOR), .TW(TW)) u_timer (
    .clk_1KHz (clk_1KHz),
    .rst      (rst),
    .en       (t_en),
    .clr      (t_clr),
    .done     (t_done)
  );

  always_comb begin
    state_n = state;
    drc_n   = drc_q;
    floor_n = floor_q;
    lock_n  = 1'b0;
    cnt_n   = '0;
    t_en    = 1'b0;
    t_clr   = 1'b0;
    // A fault with the car already home parks it regardless of state.
    if (bus.err && floor_q == F1) begin
      state_n = WAIT;
      drc_n   = DRC_WAIT;
      t_clr   = 1'b1;
    end else begin
      unique case (state)
        WAIT: begin
          if (bus.err) begin
            state_n = RUN;
            drc_n   = DRC_DN;
          end else if (!bus.arrival || !bus.door) begin
            state_n = HOLD;
          end else if (above) begin
            state_n = RUN;
            drc_n   = DRC_UP;
          end else if (below) begin
            state_n = RUN;
            drc_n   = DRC_DN;
          end
        end
        RUN: begin
          if (bus.err && drc_q != DRC_DN) begin
            drc_n = DRC_DN;
            t_clr = 1'b1;
          end else begin
            t_en = 1'b1;
            if (t_done) begin
              if (drc_q == DRC_UP && floor_q != F4)      floor_n = floor_q + 2'd1;
              else if (drc_q == DRC_DN && floor_q != F1) floor_n = floor_q - 2'd1;
              lock_n  = 1'b1;
              state_n = CHECK;
            end
          end
        end
        CHECK: begin
          cnt_n = cnt_q + 8'd1;
          if (bus.err) begin
            drc_n = DRC_DN;
            if (cnt_q == 8'(ARR_WAIT - 1)) state_n = RUN;
          end else if (!bus.arrival) begin
            state_n = HOLD;
          end else if (cnt_q == 8'(ARR_WAIT - 1)) begin
            drc_n   = scan_next(drc_q, above, below, floor_q);
            state_n = (scan_next(drc_q, above, below, floor_q) == DRC_WAIT) ? WAIT : RUN;
          end
        end
        HOLD: begin
          if (bus.err) begin
            state_n = RUN;
            drc_n   = DRC_DN;
          end else if (bus.arrival && bus.door) begin
            drc_n   = scan_next(drc_q, above, below, floor_q);
            state_n = (scan_next(drc_q, above, below, floor_q) == DRC_WAIT) ? WAIT : RUN;
          end
        end
        default: state_n = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      state   <= WAIT;
      drc_q   <= DRC_WAIT;
      floor_q <= F1;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      drc_q   <= drc_n;
      floor_q <= floor_n;
      lock_q  <= lock_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.c_floor = floor_q;
  assign bus.drc     = drc_q;
  assign bus.lock    = lock_q;

endmodule
